dfd_mux_sel_gen: RTL



---
 rtl/dfd_mux_sel_gen_pkg.sv | 32 +++
 rtl/dfd_fg_tstamp.sv | 66 ++++++
 rtl/dfd_mux_sel_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dfd_mux_sel_gen_pkg.sv
// dfd_mux_sel_gen shared encodings and helpers.
// Select-code layout: input lanes, then timestamp, then zero.
package dfd_mux_sel_gen_pkg;

   localparam int FG_TSTAMP_WIDTH = 8;
   localparam int LANE_SEL_MAX_W  = 8;

   typedef logic [LANE_SEL_MAX_W-1:0] lane_sel_t;

   function automatic lane_sel_t sel_ts(input int n);
      return lane_sel_t'(n);
   endfunction

   function automatic lane_sel_t sel_zero(input int n);
      return lane_sel_t'(n + 1);
   endfunction

   function automatic logic is_in_lane(
      input lane_sel_t c,
      input int        n
   );
      return (c < sel_ts(n));
   endfunction

   function automatic logic is_ts_lane(
      input lane_sel_t c,
      input int        n
   );
      return (c == sel_ts(n));
   endfunction

endpackage

// File: rtl/dfd_fg_tstamp.sv
// Fine-grain timestamp: saturating counter, tick clear,
// sticky saturation flag and change-time capture register.
module dfd_fg_tstamp
   import dfd_mux_sel_gen_pkg::*;
#(
   parameter int TW = FG_TSTAMP_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          tick,
   input  logic          capture,
   output logic [TW-1:0] cnt_next,
   output logic [TW-1:0] captured,
   output logic          sat
);

   localparam logic [TW-1:0] CNT_MAX = '1;

   logic [TW-1:0] r_cnt;
   logic [TW-1:0] r_captured;
   logic          r_sat;

   // next count: tick clears, otherwise count up and stick at max
   always_comb begin
      cnt_next = r_cnt;
      if (tick) begin
         cnt_next = '0;
      end else if (r_cnt != CNT_MAX) begin
         cnt_next = r_cnt + TW'(1);
      end
   end

   // counter advances with enable; a tick clears it regardless
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (en || tick) begin
         r_cnt <= cnt_next;
      end
   end

   // sticky saturation flag, tick has priority
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sat <= 1'b0;
      end else if (tick) begin
         r_sat <= 1'b0;
      end else if (en && (cnt_next == CNT_MAX)) begin
         r_sat <= 1'b1;
      end
   end

   // time of last bus change
   always_ff @(posedge clk) begin
      if (reset) begin
         r_captured <= '0;
      end else if (capture) begin
         r_captured <= cnt_next;
      end
   end

   assign captured = r_captured;
   assign sat      = r_sat;

endmodule

// File: rtl/dfd_mux_sel_gen.sv
// Debug-bus lane selector with change strobe and freeze.
// Optional DFD_MUX_SEL_GEN_CHG_CNT_EN adds chg_cnt output.
module dfd_mux_sel_gen
   import dfd_mux_sel_gen_pkg::*;
#(
   parameter  int LANE_WIDTH   = 16,
   parameter  int NUM_IN_LANES = 16,
   parameter  int OUT_LANES    = 4,
   parameter  int TSTAMP_WIDTH = FG_TSTAMP_WIDTH,
   localparam int SEL_W        = $clog2(NUM_IN_LANES + 2),
   localparam int BUS_W        = LANE_WIDTH * OUT_LANES,
   localparam int IN_W         = LANE_WIDTH * NUM_IN_LANES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IN_W-1:0]            lanes_in,
   input  logic                       time_tick,
   input  logic                       cfg_en,
   input  logic                       cfg_freeze,
   input  logic [OUT_LANES*SEL_W-1:0] cfg_lane_sel,
   output logic [BUS_W-1:0]           debug_bus,
   output logic                       debug_bus_vld,
`ifdef DFD_MUX_SEL_GEN_CHG_CNT_EN
   output logic [15:0]                chg_cnt,
`endif
   output logic                       tstamp_sat
);

   logic [IN_W-1:0]         r_lanes;
   logic [BUS_W-1:0]        r_bus;
   logic                    r_vld;

   lane_sel_t               w_sel    [OUT_LANES];
   logic [LANE_WIDTH-1:0]   w_in_val [OUT_LANES];
   logic                    w_chg;
   logic                    w_upd;
   logic                    w_capture;
   logic [TSTAMP_WIDTH-1:0] w_cnt_next;
   logic [TSTAMP_WIDTH-1:0] w_captured;
   logic [TSTAMP_WIDTH-1:0] w_cap_new;
   logic [LANE_WIDTH-1:0]   w_ts_lane;
   logic [BUS_W-1:0]        w_bus_nxt;
   logic                    w_sat;

   // stage 1: input lanes, held while disabled
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lanes <= '0;
      end else if (cfg_en) begin
         r_lanes <= lanes_in;
      end
   end

   // decode per-lane select and fetch the chosen input lane
   always_comb begin
      for (int o = 0; o < OUT_LANES; o++) begin
         w_sel[o]    = lane_sel_t'(cfg_lane_sel[o*SEL_W +: SEL_W]);
         w_in_val[o] = '0;
         for (int i = 0; i < NUM_IN_LANES; i++) begin
            if (w_sel[o] == lane_sel_t'(i)) begin
               w_in_val[o] = r_lanes[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // change: only input-lane selections can differ
   always_comb begin
      w_chg = 1'b0;
      for (int o = 0; o < OUT_LANES; o++) begin
         if (is_in_lane(w_sel[o], NUM_IN_LANES) &&
             (w_in_val[o] != r_bus[o*LANE_WIDTH +: LANE_WIDTH])) begin
            w_chg = 1'b1;
         end
      end
   end

   assign w_upd     = cfg_en & ~cfg_freeze;
   assign w_capture = w_chg & w_upd;
   assign w_cap_new = w_capture ? w_cnt_next : w_captured;

   // timestamp lane, zero-extended
   always_comb begin
      w_ts_lane                   = '0;
      w_ts_lane[TSTAMP_WIDTH-1:0] = w_cap_new;
   end

   dfd_fg_tstamp #(
      .TW       (TSTAMP_WIDTH)
   ) u_tstamp (
      .clk      (clk),
      .reset    (reset),
      .en       (cfg_en),
      .tick     (time_tick),
      .capture  (w_capture),
      .cnt_next (w_cnt_next),
      .captured (w_captured),
      .sat      (w_sat)
   );

   // assemble next bus from per-lane selections
   always_comb begin
      w_bus_nxt = '0;
      for (int o = 0; o < OUT_LANES; o++) begin
         unique case (1'b1)
            is_in_lane(w_sel[o], NUM_IN_LANES):
               w_bus_nxt[o*LANE_WIDTH +: LANE_WIDTH] = w_in_val[o];
            is_ts_lane(w_sel[o], NUM_IN_LANES):
               w_bus_nxt[o*LANE_WIDTH +: LANE_WIDTH] = w_ts_lane;
            default:
               w_bus_nxt[o*LANE_WIDTH +: LANE_WIDTH] = '0;
         endcase
      end
   end

   // stage 2: bus and change strobe; frozen or disabled holds
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bus <= '0;
         r_vld <= 1'b0;
      end else if (w_upd) begin
         r_bus <= w_bus_nxt;
         r_vld <= w_chg;
      end else begin
         r_vld <= 1'b0;
      end
   end

`ifdef DFD_MUX_SEL_GEN_CHG_CNT_EN
   logic [15:0] r_chg_cnt;

   // strobe counter, saturating, cleared by tick
   always_ff @(posedge clk) begin
      if (reset) begin
         r_chg_cnt <= '0;
      end else if (time_tick) begin
         r_chg_cnt <= '0;
      end else if (r_vld && (r_chg_cnt != 16'hFFFF)) begin
         r_chg_cnt <= r_chg_cnt + 16'd1;
      end
   end

   assign chg_cnt = r_chg_cnt;
`endif

   assign debug_bus     = r_bus;
   assign debug_bus_vld = r_vld;
   assign tstamp_sat    = w_sat;

endmodule
